// File: rtl/alu_exec_unit.sv
// RV32 execute-stage ALU: simple ops registered in 1 cycle, shifts iterate 1 bit/cycle (N+1 cycles).
// Accepts only in IDLE; result/zero are held in DONE for as long as out_ready stays low.
module alu_exec_unit #(
  parameter int XLEN = 32,
  parameter int SHW  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

  logic [1:0]      state;
  logic [XLEN-1:0] work;
  logic [XLEN-1:0] work_nxt;
  logic [XLEN-1:0] res_q;
  logic [XLEN-1:0] simple_res;
  logic [SHW-1:0]  cnt;
  logic [SHW-1:0]  shamt;
  logic            dir_right;
  logic            zero_q;
  logic            is_shift;

  assign shamt     = op_b[SHW-1:0];
  assign is_shift  = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = res_q;
  assign zero      = zero_q;

  assign work_nxt = dir_right ? {1'b0, work[XLEN-1:1]} : {work[XLEN-2:0], 1'b0};

  // Shifts only reach this path with shamt == 0, so they pass op_a through.
  always_comb begin
    simple_res = '0;
    case (alu_ctrl)
      OP_ADD:  simple_res = op_a + op_b;
      OP_SUB:  simple_res = op_a - op_b;
      OP_XOR:  simple_res = op_a ^ op_b;
      OP_OR:   simple_res = op_a | op_b;
      OP_AND:  simple_res = op_a & op_b;
      OP_SLL:  simple_res = op_a;
      OP_SRL:  simple_res = op_a;
      OP_SLT:  simple_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default: simple_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      work      <= '0;
      cnt       <= '0;
      dir_right <= 1'b0;
      res_q     <= '0;
      zero_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (is_shift && (shamt != '0)) begin
              work      <= op_a;
              cnt       <= shamt;
              dir_right <= (alu_ctrl == OP_SRL);
              state     <= SHIFT;
            end else begin
              res_q  <= simple_res;
              zero_q <= (simple_res == '0);
              state  <= DONE;
            end
          end
        end
        SHIFT: begin
          work <= work_nxt;
          cnt  <= cnt - CNT_ONE;
          // Last step: counter goes 1 -> 0 on this edge.
          if (cnt == CNT_ONE) begin
            res_q  <= work_nxt;
            zero_q <= (work_nxt == '0);
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: latency, results, back-pressure and async reset.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  int tests;
  int fails;

  alu_exec_unit #(.XLEN(32), .SHW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op, scramble inputs after acceptance, wait for out_valid (bounded).
  task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic exp_zero, input int exp_lat);
    int lat;
    logic busy_bad;
    chk({tag, " in_ready before"}, {31'd0, in_ready}, 32'd1);
    alu_ctrl = c;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a     = ~a;
    op_b     = ~b;
    alu_ctrl = 4'h3;
    lat      = 1;
    busy_bad = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " in_ready low while busy"}, {31'd0, busy_bad | in_ready}, 32'd0);
    chk({tag, " result"}, result, exp_res);
    chk({tag, " zero"}, {31'd0, zero}, {31'd0, exp_zero});
  endtask

  task automatic handshake(input string tag, input logic [31:0] exp_res);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " idle after handshake"}, {30'd0, in_ready, out_valid}, 32'd2);
    chk({tag, " result retained"}, result, exp_res);
  endtask

  initial begin
    logic hold_bad;
    logic spurious;
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    alu_ctrl  = 4'h0;
    op_a      = 32'h0;
    op_b      = 32'h0;
    out_ready = 1'b0;

    #12;
    chk("reset in_ready",  {31'd0, in_ready},  32'd1);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset result",    result,             32'h0);
    chk("reset zero",      {31'd0, zero},      32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add wrap", 4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1);
    handshake("add wrap", 32'h0000_0000);
    run_op("sub", 4'b0001, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1);
    handshake("sub", 32'hFFFF_FFFE);
    run_op("slt signed", 4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1);
    handshake("slt signed", 32'h0000_0001);
    run_op("slt false", 4'b0111, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1);
    handshake("slt false", 32'h0000_0000);
    run_op("or", 4'b0011, 32'hF0F0_0000, 32'h0000_000F, 32'hF0F0_000F, 1'b0, 1);
    handshake("or", 32'hF0F0_000F);
    run_op("and", 4'b0100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1);
    handshake("and", 32'h00F0_00F0);
    run_op("sll 31", 4'b0101, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 32);
    handshake("sll 31", 32'h8000_0000);
    run_op("srl 4", 4'b0110, 32'h8000_0000, 32'hFFFF_FFE4, 32'h0800_0000, 1'b0, 5);
    handshake("srl 4", 32'h0800_0000);
    run_op("srl 0", 4'b0110, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1'b0, 1);
    handshake("srl 0", 32'h1234_5678);
    run_op("sll out", 4'b0101, 32'h0000_0003, 32'h0000_001F, 32'h8000_0000, 1'b0, 32);
    handshake("sll out", 32'h8000_0000);
    run_op("unsupported", 4'b1010, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_0000, 1'b1, 1);
    handshake("unsupported", 32'h0000_0000);

    run_op("xor bp", 4'b0010, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 1'b0, 1);
    hold_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (result !== 32'h5A5A_A5A5 || in_ready !== 1'b0 || out_valid !== 1'b1 || zero !== 1'b0)
        hold_bad = 1'b1;
    end
    chk("backpressure hold", {31'd0, hold_bad}, 32'd0);
    handshake("xor bp", 32'h5A5A_A5A5);

    // Reset in the middle of a 20-bit shift.
    alu_ctrl = 4'b0101;
    op_a     = 32'h0000_0001;
    op_b     = 32'd20;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset out_valid", {31'd0, out_valid}, 32'd0);
    chk("midreset result",    result,             32'h0);
    chk("midreset zero",      {31'd0, zero},      32'd0);
    chk("midreset in_ready",  {31'd0, in_ready},  32'd1);
    @(posedge clk); #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    spurious = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready || result !== 32'h0) spurious = 1'b1;
    end
    out_ready = 1'b0;
    chk("no stale output after reset", {31'd0, spurious}, 32'd0);
    run_op("add after reset", 4'b0000, 32'd3, 32'd4, 32'd7, 1'b0, 1);
    handshake("add after reset", 32'd7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
